updown_counter_sync: RTL
========================

# updown_counter_sync

Synchronous, parametrised successor to the LS193 up/down counter. It provides a WIDTH-bit counter with programmable terminal count, synchronous clear and load, and registered active-low carry/borrow pulses. UP/DOWN are legacy pulse-style inputs that are synchronised and rising-edge detected on the single clock, so the block replaces the multi-edge LS193 inside fully synchronous designs.

## Interface
- WIDTH, 4, counter width in bits (≥2).
- MAX_COUNT, 2**WIDTH-1, terminal count; legal range 1 … 2**WIDTH-1; count range is 0 … MAX_COUNT.
- CLK  input  1  sole clock; all state updates on rising edge.
- RST_Bar  input  1  reset, synchronous, active-low.
- CLR  input  1  synchronous clear, active high.
- LOAD_Bar  input  1  synchronous preset, active low.
- DIN  input  WIDTH  preset data, bit 0 LSB.
- UP  input  1  count-up request; may be asynchronous; counts on rising edge.
- DOWN  input  1  count-down request; may be asynchronous; counts on rising edge.
- Q  output  WIDTH  count value.
- CO_Bar  output  1  carry, active low, one-cycle pulse.
- BO_Bar  output  1  borrow, active low, one-cycle pulse.
- DIR  output  1  last accepted direction: 1 = up, 0 = down.

## Operation
- UP and DOWN each pass through a 2-flop synchroniser followed by a history flop. rise_up = s2 & ~s3; rise_dn is formed the same way.
- Priority per edge: RST_Bar low > CLR high > LOAD_Bar low > count event.
- RST_Bar low:
  - Q=0, CO_Bar=1, BO_Bar=1, DIR=1.
  - All synchroniser/history flops set to 1, so a level held across reset produces no count.
- CLR high: Q←0. CO_Bar and BO_Bar are forced to 1. DIR is unchanged.
- LOAD_Bar low: Q←DIN. If DIN > MAX_COUNT, Q←MAX_COUNT (clamp). CO_Bar and BO_Bar are forced to 1.
- Any rise_up/rise_dn in a clear or load cycle is discarded, not deferred.
- Count event, evaluated only when there is no clear and no load:
  - rise_up only: if Q==MAX_COUNT, then Q←0 and CO_Bar←0 for the next cycle; otherwise Q←Q+1. DIR←1.
  - rise_dn only: if Q==0, then Q←MAX_COUNT and BO_Bar←0 for the next cycle; otherwise Q←Q−1. DIR←0.
  - rise_up and rise_dn in the same cycle: Q holds, DIR holds, no pulse.
  - No event: Q holds. CO_Bar and BO_Bar return to 1.
- CO_Bar and BO_Bar are registered. Each is low for exactly one cycle per wrap event and never low simultaneously.
- Arithmetic is WIDTH bits. Q never exceeds MAX_COUNT under any stimulus.

## Timing
- UP or DOWN first sampled high at edge n (with the prior sample low): Q updates at edge n+2. Input-to-Q latency is 2 cycles.
- CO_Bar/BO_Bar go low at the same edge as the wrapping Q update and return high at the next edge.
- CLR and LOAD_Bar take effect at the first edge at which they are sampled active (0-cycle latency).
- Minimum UP/DOWN high and low time is 2 CLK periods for guaranteed detection. Back-to-back counts are possible every 2 cycles.
- An input edge arriving while CLR or LOAD_Bar is active is lost if its rise cycle coincides with the clear/load. If the rise cycle falls after the clear/load, it counts normally.
- Reset mid-count: the next edge yields reset values. Pulses in flight are cancelled.

## Configuration
- COUNT_SAT_EN defined:
  - Counting up at MAX_COUNT holds Q=MAX_COUNT and still pulses CO_Bar low for one cycle.
  - Counting down at 0 holds Q=0 and still pulses BO_Bar low.
  - DIR updates as normal.
- COUNT_SAT_EN undefined: wrap-around behaviour as in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset then count up, WIDTH=4, MAX_COUNT=15: assert RST_Bar=0 for 2 cycles, release, then apply 16 UP pulses (3 high / 3 low cycles each). Required: Q steps 0→1…15→0; CO_Bar low for exactly 1 cycle, at the edge Q becomes 0; DIR=1.
- Decade borrow, MAX_COUNT=9: from Q=0, apply 1 DOWN pulse. Required: Q=9 at edge n+2 and BO_Bar low for 1 cycle. A further 9 DOWN pulses give Q=0 with no further BO_Bar pulse.
- Load clamp, MAX_COUNT=9: apply LOAD_Bar=0 with DIN=4'hC for 1 cycle. Required: Q=9 at that edge. Then apply LOAD_Bar=0 with DIN=3. Required: Q=3.
- Simultaneous and priority:
  - Raise UP and DOWN at the same edge. Required: Q unchanged, no pulse, DIR unchanged.
  - Assert CLR and LOAD_Bar=0 (DIN=5) together. Required: Q=0.
  - Apply a rise_up coinciding with LOAD_Bar=0 and DIN=7. Required: Q=7, not 8.
- Reset with held level: hold UP=1 through reset and release. Required: no count. The next full low→high UP cycle gives Q=1.
- COUNT_SAT_EN build, WIDTH=4: from Q=15, apply 1 UP pulse. Required: Q stays 15 and CO_Bar pulses low for 1 cycle. From Q=0, apply 1 DOWN pulse. Required: Q stays 0 and BO_Bar pulses low for 1 cycle.

Source files
------------

// File: rtl/updown_counter_sync.sv
// Synchronous up/down counter with programmable terminal count, clear/load and carry/borrow pulses.
// Optional build macro COUNT_SAT_EN: saturate at the ends instead of wrapping.
module updown_counter_sync #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1
) (
  input  logic             CLK,
  input  logic             RST_Bar,
  input  logic             CLR,
  input  logic             LOAD_Bar,
  input  logic [WIDTH-1:0] DIN,
  input  logic             UP,
  input  logic             DOWN,
  output logic [WIDTH-1:0] Q,
  output logic             CO_Bar,
  output logic             BO_Bar,
  output logic             DIR
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic             up_s1_q, up_s2_q, up_s3_q;
  logic             up_s1_d, up_s2_d, up_s3_d;
  logic             dn_s1_q, dn_s2_q, dn_s3_q;
  logic             dn_s1_d, dn_s2_d, dn_s3_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             co_n_q, co_n_d;
  logic             bo_n_q, bo_n_d;
  logic             dir_q, dir_d;
  logic             rise_up, rise_dn;

  // Sync reset parks the synchronisers high so a level held through reset never counts.
  always_ff @(posedge CLK) begin
    if (!RST_Bar) begin
      up_s1_q <= 1'b1;
      up_s2_q <= 1'b1;
      up_s3_q <= 1'b1;
      dn_s1_q <= 1'b1;
      dn_s2_q <= 1'b1;
      dn_s3_q <= 1'b1;
      q_q     <= '0;
      co_n_q  <= 1'b1;
      bo_n_q  <= 1'b1;
      dir_q   <= 1'b1;
    end else begin
      up_s1_q <= up_s1_d;
      up_s2_q <= up_s2_d;
      up_s3_q <= up_s3_d;
      dn_s1_q <= dn_s1_d;
      dn_s2_q <= dn_s2_d;
      dn_s3_q <= dn_s3_d;
      q_q     <= q_d;
      co_n_q  <= co_n_d;
      bo_n_q  <= bo_n_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    up_s1_d = UP;
    up_s2_d = up_s1_q;
    up_s3_d = up_s2_q;
    dn_s1_d = DOWN;
    dn_s2_d = dn_s1_q;
    dn_s3_d = dn_s2_q;
    rise_up = up_s2_q & ~up_s3_q;
    rise_dn = dn_s2_q & ~dn_s3_q;
    q_d     = q_q;
    co_n_d  = 1'b1;
    bo_n_d  = 1'b1;
    dir_d   = dir_q;

    // Clear beats load beats counting; rises during clear/load are dropped.
    if (CLR) begin
      q_d = '0;
    end else if (!LOAD_Bar) begin
      q_d = (DIN > MAX_Q) ? MAX_Q : DIN;
    end else if (rise_up && !rise_dn) begin
      dir_d = 1'b1;
      if (q_q == MAX_Q) begin
        co_n_d = 1'b0;
`ifdef COUNT_SAT_EN
        q_d    = MAX_Q;
`else
        q_d    = '0;
`endif
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end else if (rise_dn && !rise_up) begin
      dir_d = 1'b0;
      if (q_q == '0) begin
        bo_n_d = 1'b0;
`ifdef COUNT_SAT_EN
        q_d    = '0;
`else
        q_d    = MAX_Q;
`endif
      end else begin
        q_d = q_q - WIDTH'(1);
      end
    end
  end

  assign Q      = q_q;
  assign CO_Bar = co_n_q;
  assign BO_Bar = bo_n_q;
  assign DIR    = dir_q;

endmodule
